// File: rtl/fop_stream_pkg.sv
// Shared constants, state encoding and frame sizing for the fop serial front end.
// Frame length grows to 5 bits when FOP_STREAM_PARITY_EN is defined.
package fop_stream_pkg;

    localparam logic [15:0] FOP_SET_MASK = 16'h29AF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int FRAME_LEN_DATA   = 4;
    localparam int FRAME_LEN_PARITY = 5;

`ifdef FOP_STREAM_PARITY_EN
    localparam int FRAME_LEN = FRAME_LEN_PARITY;
`else
    localparam int FRAME_LEN = FRAME_LEN_DATA;
`endif

    localparam int              CNT_IDX_W = 3;
    localparam logic [CNT_IDX_W-1:0] LAST_IDX = CNT_IDX_W'(FRAME_LEN - 1);

endpackage

// File: rtl/fop_stream_fop_b.sv
// Existing behavioural fop stage: flags nibbles that belong to the fop set.
module fop_B
    import fop_stream_pkg::*;
(
    input  logic [3:0] nib,
    output logic       fop
);

    always_comb begin
        fop = FOP_SET_MASK[nib];
    end

endmodule

// File: rtl/fop_stream.sv
// Serial-to-nibble front end for the fop stage with valid/ready output and saturating hit counter.
// Optional FOP_STREAM_PARITY_EN adds an even-parity bit per frame and the parity_err output.
module fop_stream
    import fop_stream_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       nib_out,
    output logic             fop_out,
    output logic [CNT_W-1:0] hit_cnt
`ifdef FOP_STREAM_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_IDX_W-1:0]   bit_cnt;
    logic [FRAME_LEN-2:0]   shift_reg;
    logic [FRAME_LEN-1:0]   frame_word;
    logic [3:0]             frame_nib;
    logic                   frame_fop;
    logic                   bit_take;
    logic                   frame_done;
    logic                   xfer;
    logic                   hit_inc;

    // The incoming bit completes the frame combinationally so the last bit can be captured directly.
    assign frame_word = {shift_reg, bit_in};
    assign frame_nib  = frame_word[FRAME_LEN-1 -: 4];

    fop_B u_fop (
        .nib (frame_nib),
        .fop (frame_fop)
    );

`ifdef FOP_STREAM_PARITY_EN
    assign hit_inc = xfer && fop_out && !parity_err;
`else
    assign hit_inc = xfer && fop_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bit_ready  = 1'b0;
        bit_take   = 1'b0;
        frame_done = 1'b0;
        xfer       = 1'b0;
        case (state)
            COLLECT: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    bit_take = 1'b1;
                    if (bit_cnt == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    xfer      = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            out_valid  <= 1'b0;
            nib_out    <= '0;
            fop_out    <= 1'b0;
`ifdef FOP_STREAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (bit_take) begin
                shift_reg <= frame_word[FRAME_LEN-2:0];
                bit_cnt   <= frame_done ? '0 : bit_cnt + CNT_IDX_W'(1);
            end
            // nib_out/fop_out are only rewritten by a new frame, so they persist after transfer.
            if (frame_done) begin
                out_valid  <= 1'b1;
                nib_out    <= frame_nib;
                fop_out    <= frame_fop;
`ifdef FOP_STREAM_PARITY_EN
                parity_err <= ^frame_word;
`endif
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (hit_inc && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fop_stream.sv
// Self-checking bench for fop_stream: directed test-plan steps then randomized traffic vs a reference model.
// Two DUT copies (CNT_W=8 and CNT_W=2) share stimulus so counter saturation is observed alongside normal counting.
module tb_fop_stream;

`ifdef FOP_STREAM_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ready;

    logic       br8, ov8, fop8;
    logic [3:0] nib8;
    logic [7:0] hit8;
    logic       br2, ov2, fop2;
    logic [3:0] nib2;
    logic [1:0] hit2;
`ifdef FOP_STREAM_PARITY_EN
    logic       perr8, perr2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_hold, m_n, m_acc, m_nib, m_fop, m_perr, m_hits8, m_hits2;
    int fop_set[9] = '{0, 1, 2, 3, 5, 7, 8, 11, 13};

    fop_stream #(.CNT_W(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (br8),
        .out_ready  (out_ready),
        .out_valid  (ov8),
        .nib_out    (nib8),
        .fop_out    (fop8),
        .hit_cnt    (hit8)
`ifdef FOP_STREAM_PARITY_EN
        ,
        .parity_err (perr8)
`endif
    );

    fop_stream #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (br2),
        .out_ready  (out_ready),
        .out_valid  (ov2),
        .nib_out    (nib2),
        .fop_out    (fop2),
        .hit_cnt    (hit2)
`ifdef FOP_STREAM_PARITY_EN
        ,
        .parity_err (perr2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int in_fop_set(input int v);
        foreach (fop_set[i]) if (fop_set[i] == v) return 1;
        return 0;
    endfunction

    // Frame bits for a nibble, MSB first; parity mode appends an even-parity bit.
    function automatic logic [4:0] makeFrame(input logic [3:0] n);
`ifdef FOP_STREAM_PARITY_EN
        return {n, ^n};
`else
        return {1'b0, n};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic bv, input logic bi, input logic ordy);
        if (r) begin
            m_hold = 0; m_n = 0; m_acc = 0; m_nib = 0; m_fop = 0; m_perr = 0;
            m_hits8 = 0; m_hits2 = 0;
        end else if (m_hold != 0) begin
            if (ordy) begin
                m_hold = 0;
                if (m_fop != 0 && m_perr == 0) begin
                    m_hits8 = (m_hits8 < 255) ? m_hits8 + 1 : 255;
                    m_hits2 = (m_hits2 < 3) ? m_hits2 + 1 : 3;
                end
            end
        end else if (bv) begin
            m_acc = m_acc * 2 + int'(bi);
            m_n++;
            if (m_n == FRAME) begin
                m_hold = 1;
                m_nib  = (FRAME == 5) ? m_acc / 2 : m_acc;
                m_perr = (FRAME == 5) ? ($countones(m_acc) % 2) : 0;
                m_fop  = in_fop_set(m_nib);
                m_n    = 0;
                m_acc  = 0;
            end
        end
    endtask

    task automatic checkOutput();
        chk("out_valid", ov8, m_hold);
        chk("out_valid_w2", ov2, m_hold);
        chk("bit_ready", br8, (m_hold == 0));
        chk("nib_out", nib8, m_nib);
        chk("fop_out", fop8, m_fop);
        chk("hit_cnt_w8", hit8, m_hits8);
        chk("hit_cnt_w2", hit2, m_hits2);
`ifdef FOP_STREAM_PARITY_EN
        if (m_hold != 0) chk("parity_err", perr8, m_perr);
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic bv, input logic bi, input logic ordy);
        rst       = r;
        bit_valid = bv;
        bit_in    = bi;
        out_ready = ordy;
        @(posedge clk);
        modelStep(r, bv, bi, ordy);
        #1;
        checkOutput();
    endtask

    task automatic sendFrame(input logic [4:0] bits, input int len, input int gaps, input logic ordy);
        for (int i = len - 1; i >= 0; i--) begin
            if (gaps != 0 && i != len - 1) applyStimulus(1'b0, 1'b0, 1'($urandom), ordy);
            applyStimulus(1'b0, 1'b1, bits[i], ordy);
        end
    endtask

    int         exp_sat[4] = '{1, 2, 3, 3};
    int         hits_before;
    logic [4:0] fr;

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        m_hold = 0; m_n = 0; m_acc = 0; m_nib = 0; m_fop = 0; m_perr = 0;
        m_hits8 = 0; m_hits2 = 0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_out_valid", ov8, 0);
        chk("reset_bit_ready", br8, 1);
        chk("reset_nib", nib8, 0);
        chk("reset_hit", hit8, 0);
`ifdef FOP_STREAM_PARITY_EN
        chk("reset_parity_err", perr8, 0);
`endif

        $display("[TB] frame 0101");
        sendFrame(makeFrame(4'h5), FRAME, 0, 1'b1);
        chk("f5_valid", ov8, 1);
        chk("f5_nib", nib8, 4'h5);
        chk("f5_fop", fop8, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f5_hit", hit8, 1);

        $display("[TB] frame 0100");
        sendFrame(makeFrame(4'h4), FRAME, 0, 1'b1);
        chk("f4_nib", nib8, 4'h4);
        chk("f4_fop", fop8, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f4_hit", hit8, 1);

        $display("[TB] backpressure");
        sendFrame(makeFrame(4'h9), FRAME, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0);
            chk("bp_valid", ov8, 1);
            chk("bp_bit_ready", br8, 0);
            chk("bp_nib", nib8, 4'h9);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        chk("bp_xfer_valid", ov8, 0);
        sendFrame(makeFrame(4'h3), FRAME, 0, 1'b0);
        chk("bp_next_nib", nib8, 4'h3);
        chk("bp_next_fop", fop8, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] gapped frame 1101");
        sendFrame(makeFrame(4'hD), FRAME, 1, 1'b0);
        chk("gap_nib", nib8, 4'hD);
        chk("gap_fop", fop8, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sendFrame(makeFrame(4'h0), FRAME, 0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            chk("sat_hit_w2", hit2, exp_sat[k]);
        end
        chk("sat_hit_w8", hit8, 4);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendFrame(makeFrame(4'h8), FRAME, 0, 1'b0);
        chk("rst_mid_valid", ov8, 1);
        chk("rst_mid_nib", nib8, 4'h8);
        chk("rst_mid_fop", fop8, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef FOP_STREAM_PARITY_EN
        $display("[TB] parity");
        hits_before = int'(hit8);
        fr = 5'b01011;
        sendFrame(fr, 5, 0, 1'b0);
        chk("par_bad_err", perr8, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_bad_hit", hit8, hits_before);
        fr = 5'b01010;
        sendFrame(fr, 5, 0, 1'b0);
        chk("par_good_err", perr8, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_good_hit", hit8, hits_before + 1);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            applyStimulus(1'($urandom_range(0, 199) == 0),
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom),
                          1'($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
